// File: rtl/alu_wb_if.sv
// alu_wb_if: handshake and data bundle between the ALU, the write-back
// stage and the register-file write port. The flag outputs ride along so
// the stage has a single bus port.
interface alu_wb_if #(
  parameter int RA_W = 4
);
  logic            in_valid;
  logic            in_ready;
  logic [31:0]     alu_in1;
  logic [31:0]     alu_in2;
  logic [1:0]      alu_op;
  logic [31:0]     alu_out;
  logic            set_flags;
  logic [RA_W-1:0] rd_addr;
  logic            wb_valid;
  logic            wb_ready;
  logic [31:0]     wb_data;
  logic [RA_W-1:0] wb_addr;
  logic            flag_n;
  logic            flag_z;
  logic            flag_c;
  logic            flag_v;

  // Upstream ALU and register file side
  modport master (
    output in_valid, alu_in1, alu_in2, alu_op, alu_out, set_flags, rd_addr,
    output wb_ready,
    input  in_ready, wb_valid, wb_data, wb_addr,
    input  flag_n, flag_z, flag_c, flag_v
  );

  // Write-back stage side
  modport slave (
    input  in_valid, alu_in1, alu_in2, alu_op, alu_out, set_flags, rd_addr,
    input  wb_ready,
    output in_ready, wb_valid, wb_data, wb_addr,
    output flag_n, flag_z, flag_c, flag_v
  );
endinterface

// File: rtl/alu_wb_stage.sv
// alu_wb_stage: buffers ALU results behind a valid/ready handshake, computes
// NZCV at capture and owns the architectural flag register, updated when a
// set_flags entry retires to the register-file write port.
// Build option: define ALU_WB_SKID_EN for a 2-entry skid buffer whose
// in_ready is a pure register; otherwise a single entry register with a
// combinational in_ready.
module alu_wb_stage #(
  parameter int RA_W = 4
) (
  input  logic     clk,
  input  logic     rst_n,
  alu_wb_if.slave  bus
);

  typedef struct packed {
    logic [31:0]     data;
    logic [RA_W-1:0] addr;
    logic            set_flags;
    logic [3:0]      nzcv;
  } entry_t;

  // NZCV of one ALU result. keep_c/keep_v are the flags the entry inherits
  // when its op does not define C or V.
  function automatic logic [3:0] calc_nzcv(
    input logic [31:0] in1,
    input logic [31:0] in2,
    input logic [31:0] out,
    input logic [1:0]  op,
    input logic        keep_c,
    input logic        keep_v
  );
    logic [32:0] sum;
    logic        c;
    logic        v;
    sum = {1'b0, in1} + {1'b0, in2};
    c   = keep_c;
    v   = keep_v;
    case (op)
      2'b00: begin
        c = sum[32];
        v = (in1[31] == in2[31]) && (out[31] != in1[31]);
      end
      2'b01: begin
        c = (in2 >= in1);
        v = (in2[31] != in1[31]) && (out[31] != in2[31]);
      end
      2'b11: begin
        if (in1 != 32'd0) c = out[31];
      end
      default: ;
    endcase
    return {out[31], (out == 32'd0), c, v};
  endfunction

  // C/V as they will stand once every accepted entry has retired; this is
  // what "keep" resolves against, so it moves at accept time, not retire.
  logic   fut_c;
  logic   fut_v;
  logic [3:0] nzcv_q;

  entry_t entry_p0;
  entry_t head;
  logic   in_ready_w;
  logic   wb_valid_w;
  logic   accept;
  logic   retire;

  // Capture-side view of the incoming ALU result
  always_comb begin
    entry_p0.data      = bus.alu_out;
    entry_p0.addr      = bus.rd_addr;
    entry_p0.set_flags = bus.set_flags;
    entry_p0.nzcv      = calc_nzcv(bus.alu_in1, bus.alu_in2, bus.alu_out,
                                   bus.alu_op, fut_c, fut_v);
  end

  assign accept = bus.in_valid && in_ready_w;
  assign retire = wb_valid_w && bus.wb_ready;

`ifdef ALU_WB_SKID_EN
  entry_t     mem_p1 [2];
  logic       wr_ptr;
  logic       rd_ptr;
  logic [1:0] count;
  logic [1:0] count_next;
  logic       ready_q;

  // Occupancy after this edge; in_ready is registered from it
  always_comb begin
    count_next = count + {1'b0, accept} - {1'b0, retire};
  end

  // Two-entry FIFO; a stall absorbs one extra entry before in_ready drops
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 2; i++) mem_p1[i] <= '0;
      wr_ptr  <= 1'b0;
      rd_ptr  <= 1'b0;
      count   <= 2'd0;
      ready_q <= 1'b1;
    end else begin
      if (accept) begin
        mem_p1[wr_ptr] <= entry_p0;
        wr_ptr         <= ~wr_ptr;
      end
      if (retire) rd_ptr <= ~rd_ptr;
      count   <= count_next;
      ready_q <= (count_next != 2'd2);
    end
  end

  assign head       = mem_p1[rd_ptr];
  assign wb_valid_w = (count != 2'd0);
  assign in_ready_w = ready_q;
`else
  entry_t ent_p1;
  logic   vld_p1;

  // Single entry register; refills in the same cycle it retires
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ent_p1 <= '0;
      vld_p1 <= 1'b0;
    end else begin
      if (accept) begin
        ent_p1 <= entry_p0;
        vld_p1 <= 1'b1;
      end else if (retire) begin
        vld_p1 <= 1'b0;
      end
    end
  end

  assign head       = ent_p1;
  assign wb_valid_w = vld_p1;
  assign in_ready_w = !vld_p1 || bus.wb_ready;
`endif

  // Track the C/V the pipeline will settle on after all accepted entries
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fut_c <= 1'b0;
      fut_v <= 1'b0;
    end else if (accept && bus.set_flags) begin
      fut_c <= entry_p0.nzcv[1];
      fut_v <= entry_p0.nzcv[0];
    end
  end

  // Architectural flags change only when a set_flags entry retires
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      nzcv_q <= 4'b0000;
    end else if (retire && head.set_flags) begin
      nzcv_q <= head.nzcv;
    end
  end

  assign bus.in_ready = in_ready_w;
  assign bus.wb_valid = wb_valid_w;
  assign bus.wb_data  = head.data;
  assign bus.wb_addr  = head.addr;
  assign bus.flag_n   = nzcv_q[3];
  assign bus.flag_z   = nzcv_q[2];
  assign bus.flag_c   = nzcv_q[1];
  assign bus.flag_v   = nzcv_q[0];

endmodule

// File: tb/tb_alu_wb_stage.sv
// tb_alu_wb_stage: directed and randomized checks of alu_wb_stage against a
// queue-based reference model of the write-back stage and its flag rules.
module tb_alu_wb_stage;
`ifdef ALU_WB_SKID_EN
  localparam int CAP = 2;
`else
  localparam int CAP = 1;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  alu_wb_if #(.RA_W(4)) bus ();
  alu_wb_stage #(.RA_W(4)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  int n_cmp = 0;
  int n_bad = 0;

  typedef struct {
    logic [31:0] data;
    logic [3:0]  addr;
    logic        sf;
    logic [3:0]  nzcv;
  } ment_t;

  ment_t       mq[$];
  logic        fut_c, fut_v;
  logic [3:0]  arch;
  logic [31:0] obs_data[$], exp_data[$];
  logic [3:0]  obs_addr[$], exp_addr[$], obs_flg[$], exp_flg[$];
  logic        last_acc, last_ret;
  logic        pre_valid;
  logic [31:0] pre_data;
  logic [3:0]  pre_addr;

  function automatic logic [31:0] alu_ref(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    logic [63:0] dbl;
    case (op)
      2'd0: return a + b;
      2'd1: return b - a;
      2'd2: return a * b;
      default: begin
        dbl = {b, b} >> a[4:0];
        return dbl[31:0];
      end
    endcase
  endfunction

  // Flags from the arithmetic meaning: carry = unsigned sum overflows 32 bits,
  // V = signed result out of 32-bit range, sub C = no borrow.
  function automatic logic [3:0] ref_flags(input logic [31:0] a, input logic [31:0] b, input logic [1:0] op,
                                           input logic [31:0] out, input logic kc, input logic kv);
    longint sa, sb, s, ua, ub;
    logic c, v;
    sa = $signed(a); sb = $signed(b); ua = a; ub = b;
    c = kc; v = kv;
    if (op == 2'd0) begin
      s = sa + sb;
      v = (s > 64'sd2147483647) || (s < -64'sd2147483648);
      c = (ua + ub) > 64'sd4294967295;
    end else if (op == 2'd1) begin
      s = sb - sa;
      v = (s > 64'sd2147483647) || (s < -64'sd2147483648);
      c = (ub >= ua);
    end else if (op == 2'd3 && a != 0) begin
      c = out[31];
    end
    return {out[31], out == 32'd0, c, v};
  endfunction

  function automatic logic [3:0] flags();
    return {bus.flag_n, bus.flag_z, bus.flag_c, bus.flag_v};
  endfunction

  task automatic clear_q();
    obs_data.delete(); exp_data.delete(); obs_addr.delete(); exp_addr.delete();
    obs_flg.delete(); exp_flg.delete();
  endtask

  task automatic reset_model();
    mq.delete(); fut_c = 0; fut_v = 0; arch = 4'b0000;
  endtask

  // One clock: drive at negedge, note handshakes, advance the model after the edge
  task automatic tick(input logic v, input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                      input logic sf, input logic [3:0] rd, input logic rdy);
    ment_t e;
    @(negedge clk);
    bus.in_valid = v; bus.alu_op = op; bus.alu_in1 = a; bus.alu_in2 = b;
    bus.alu_out = alu_ref(op, a, b); bus.set_flags = sf; bus.rd_addr = rd; bus.wb_ready = rdy;
    #1;
    last_acc = bus.in_valid && bus.in_ready;
    last_ret = bus.wb_valid && bus.wb_ready;
    if (last_ret) begin
      obs_data.push_back(bus.wb_data);
      obs_addr.push_back(bus.wb_addr);
    end
    @(posedge clk);
    #1;
    if (last_ret && mq.size() > 0) begin
      e = mq.pop_front();
      exp_data.push_back(e.data);
      exp_addr.push_back(e.addr);
      if (e.sf) arch = e.nzcv;
      exp_flg.push_back(arch);
      obs_flg.push_back(flags());
    end
    if (last_acc) begin
      e.data = alu_ref(op, a, b); e.addr = rd; e.sf = sf;
      e.nzcv = ref_flags(a, b, op, e.data, fut_c, fut_v);
      if (sf) begin fut_c = e.nzcv[1]; fut_v = e.nzcv[0]; end
      mq.push_back(e);
    end
  endtask

  task automatic drain();
    int k;
    k = 0;
    while ((mq.size() != 0 || bus.wb_valid) && k < 20) begin
      tick(0, 2'd0, 32'd0, 32'd0, 0, 4'd0, 1);
      k++;
    end
    n_cmp++;
    if (k >= 20) begin
      n_bad++;
      $display("FAIL drain_timeout: left=%0d wb_valid=%0b required empty", mq.size(), bus.wb_valid);
    end
  endtask

  task automatic op_and_retire(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                               input logic sf, input logic [3:0] rd);
    tick(1, op, a, b, sf, rd, 0);
    pre_valid = bus.wb_valid; pre_data = bus.wb_data; pre_addr = bus.wb_addr;
    tick(0, 2'd0, 32'd0, 32'd0, 0, 4'd0, 1);
  endtask

  task automatic test_reset();
    #2;
    n_cmp++; if (bus.wb_valid !== 1'b0) begin n_bad++; $display("FAIL rst_wb_valid: got %0b want 0", bus.wb_valid); end
    n_cmp++; if (bus.wb_data !== 32'd0) begin n_bad++; $display("FAIL rst_wb_data: got %h want 0", bus.wb_data); end
    n_cmp++; if (bus.wb_addr !== 4'd0) begin n_bad++; $display("FAIL rst_wb_addr: got %h want 0", bus.wb_addr); end
    n_cmp++; if (flags() !== 4'b0000) begin n_bad++; $display("FAIL rst_flags: got %b want 0000", flags()); end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    n_cmp++; if (bus.in_ready !== 1'b1) begin n_bad++; $display("FAIL rst_in_ready: got %0b want 1", bus.in_ready); end
  endtask

  task automatic test_add();
    op_and_retire(2'd0, 32'hFFFF_FFFF, 32'd1, 1, 4'd3);
    n_cmp++; if (pre_valid !== 1'b1) begin n_bad++; $display("FAIL add_latency: wb_valid got %0b want 1", pre_valid); end
    n_cmp++; if (pre_data !== 32'd0) begin n_bad++; $display("FAIL add_data: got %h want 00000000", pre_data); end
    n_cmp++; if (pre_addr !== 4'd3) begin n_bad++; $display("FAIL add_addr: got %0d want 3", pre_addr); end
    n_cmp++; if (flags() !== 4'b0110) begin n_bad++; $display("FAIL add_flags: got %b want 0110", flags()); end
  endtask

  task automatic test_ror_mul();
    op_and_retire(2'd3, 32'd4, 32'h0000_000F, 1, 4'd5);
    n_cmp++; if (pre_data !== 32'hF000_0000) begin n_bad++; $display("FAIL ror_data: got %h want f0000000", pre_data); end
    n_cmp++; if (flags() !== 4'b1010) begin n_bad++; $display("FAIL ror_flags: got %b want 1010", flags()); end
    op_and_retire(2'd2, 32'd2, 32'd3, 1, 4'd6);
    n_cmp++; if (pre_data !== 32'd6) begin n_bad++; $display("FAIL mul_data: got %h want 6", pre_data); end
    n_cmp++; if (flags() !== 4'b0010) begin n_bad++; $display("FAIL mul_flags: got %b want 0010", flags()); end
  endtask

  task automatic test_sub();
    op_and_retire(2'd1, 32'd1, 32'h8000_0000, 1, 4'd7);
    n_cmp++; if (pre_data !== 32'h7FFF_FFFF) begin n_bad++; $display("FAIL sub_data: got %h want 7fffffff", pre_data); end
    n_cmp++; if (flags() !== 4'b0011) begin n_bad++; $display("FAIL sub_flags: got %b want 0011", flags()); end
  endtask

  task automatic test_flags_hold();
    op_and_retire(2'd0, 32'hFFFF_FFFF, 32'd1, 1, 4'd3);
    n_cmp++; if (flags() !== 4'b0110) begin n_bad++; $display("FAIL hold_pre_flags: got %b want 0110", flags()); end
    op_and_retire(2'd1, 32'd5, 32'd2, 0, 4'd9);
    n_cmp++; if (pre_data !== 32'hFFFF_FFFD) begin n_bad++; $display("FAIL hold_data: got %h want fffffffd", pre_data); end
    n_cmp++; if (flags() !== 4'b0110) begin n_bad++; $display("FAIL hold_flags: got %b want 0110", flags()); end
  endtask

  task automatic test_stall();
    int acc;
    clear_q();
    acc = 0;
    for (int i = 0; i < 3; i++) begin
      tick(1, 2'd0, 32'd100 + i, 32'd7, 1, 4'(i + 1), 0);
      if (last_acc) acc++;
    end
    n_cmp++; if (acc !== CAP) begin n_bad++; $display("FAIL stall_accepts: got %0d want %0d", acc, CAP); end
    n_cmp++; if (bus.in_ready !== 1'b0) begin n_bad++; $display("FAIL stall_in_ready: got %0b want 0", bus.in_ready); end
    n_cmp++; if (bus.wb_data !== 32'd107) begin n_bad++; $display("FAIL stall_head_stable: got %0d want 107", bus.wb_data); end
    drain();
    n_cmp++; if (obs_data.size() !== CAP || exp_data.size() !== CAP) begin
      n_bad++; $display("FAIL stall_retire_count: got %0d want %0d", obs_data.size(), CAP); end
    foreach (exp_data[i]) if (i < obs_data.size()) begin
      n_cmp++;
      if ({obs_data[i], obs_addr[i], obs_flg[i]} !== {exp_data[i], exp_addr[i], exp_flg[i]}) begin
        n_bad++; $display("FAIL stall_order[%0d]: got %h/%0d/%b want %h/%0d/%b", i,
                          obs_data[i], obs_addr[i], obs_flg[i], exp_data[i], exp_addr[i], exp_flg[i]);
      end
    end
  endtask

  task automatic test_back_to_back();
    int acc, ret, gaps;
    clear_q();
    acc = 0; ret = 0; gaps = 0;
    for (int i = 0; i < 9; i++) begin
      tick(i < 8, 2'(i), 32'(i * 3 + 1), 32'(i * 1000 + 5), 1, 4'(i), 1);
      if (last_acc) acc++;
      if (last_ret) ret++;
      if (i >= 1 && !last_ret) gaps++;
    end
    n_cmp++; if (acc !== 8) begin n_bad++; $display("FAIL b2b_accepts: got %0d want 8", acc); end
    n_cmp++; if (ret !== 8) begin n_bad++; $display("FAIL b2b_retires: got %0d want 8", ret); end
    n_cmp++; if (gaps !== 0) begin n_bad++; $display("FAIL b2b_bubbles: got %0d want 0", gaps); end
    foreach (exp_data[i]) if (i < obs_data.size()) begin
      n_cmp++;
      if ({obs_data[i], obs_addr[i], obs_flg[i]} !== {exp_data[i], exp_addr[i], exp_flg[i]}) begin
        n_bad++; $display("FAIL b2b_entry[%0d]: got %h/%0d/%b want %h/%0d/%b", i,
                          obs_data[i], obs_addr[i], obs_flg[i], exp_data[i], exp_addr[i], exp_flg[i]);
      end
    end
  endtask

  task automatic test_random();
    logic [31:0] a, b;
    clear_q();
    for (int i = 0; i < 300; i++) begin
      a = $urandom();
      b = $urandom();
      case ($urandom_range(0, 5))
        0: a = 32'd0;
        1: a = 32'hFFFF_FFFF;
        2: b = 32'h8000_0000;
        3: a = b;
        default: ;
      endcase
      tick($urandom_range(0, 3) != 0, 2'($urandom_range(0, 3)), a, b,
           1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)), $urandom_range(0, 9) < 7);
    end
    drain();
    n_cmp++; if (obs_data.size() !== exp_data.size()) begin
      n_bad++; $display("FAIL rand_retire_count: got %0d want %0d", obs_data.size(), exp_data.size()); end
    foreach (exp_data[i]) if (i < obs_data.size()) begin
      n_cmp++;
      if ({obs_data[i], obs_addr[i], obs_flg[i]} !== {exp_data[i], exp_addr[i], exp_flg[i]}) begin
        n_bad++; $display("FAIL rand_entry[%0d]: got %h/%0d/%b want %h/%0d/%b", i,
                          obs_data[i], obs_addr[i], obs_flg[i], exp_data[i], exp_addr[i], exp_flg[i]);
      end
    end
    n_cmp++; if (flags() !== arch) begin n_bad++; $display("FAIL rand_final_flags: got %b want %b", flags(), arch); end
  endtask

  task automatic test_reset_mid();
    int ret;
    op_and_retire(2'd0, 32'hFFFF_FFFF, 32'd1, 1, 4'd3);
    for (int i = 0; i < 2; i++) tick(1, 2'd0, 32'd50 + i, 32'd1, 1, 4'd2, 0);
    n_cmp++; if (bus.wb_valid !== 1'b1) begin n_bad++; $display("FAIL mid_buffered: wb_valid got %0b want 1", bus.wb_valid); end
    @(negedge clk);
    bus.in_valid = 0; bus.wb_ready = 0;
    rst_n = 1'b0;
    #1;
    n_cmp++; if (bus.wb_valid !== 1'b0) begin n_bad++; $display("FAIL mid_wb_valid: got %0b want 0", bus.wb_valid); end
    n_cmp++; if (flags() !== 4'b0000) begin n_bad++; $display("FAIL mid_flags: got %b want 0000", flags()); end
    reset_model();
    @(negedge clk);
    rst_n = 1'b1;
    ret = 0;
    for (int i = 0; i < 4; i++) begin
      tick(0, 2'd0, 32'd0, 32'd0, 0, 4'd0, 1);
      if (last_ret) ret++;
    end
    n_cmp++; if (ret !== 0) begin n_bad++; $display("FAIL mid_no_writeback: got %0d retires want 0", ret); end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    bus.in_valid = 0; bus.alu_in1 = 0; bus.alu_in2 = 0; bus.alu_op = 0; bus.alu_out = 0;
    bus.set_flags = 0; bus.rd_addr = 0; bus.wb_ready = 0;
    last_acc = 0; last_ret = 0;
    reset_model();
    clear_q();
    test_reset();
    test_add();
    test_ror_mul();
    test_sub();
    test_flags_hold();
    test_stall();
    test_back_to_back();
    test_random();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
